// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: radix-2 shift-add sequencer for MULT/MULTU producing a {HI,LO} product
module mult_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_signed,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_busy,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_product
);
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;
  state_t               r_state;
  logic [CNT_W-1:0]     r_count;
  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]     r_mplr;
  logic [WIDTH:0]       r_acc;
  logic                 r_neg;
  logic                 r_busy;
  logic                 r_done;
  logic [2*WIDTH-1:0]   r_product;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_mag;
  // partial sum for this step; the carry lands in bit WIDTH
  always_comb begin
    w_sum = r_acc + {1'b0, r_mplr[0] ? r_mcand : '0};
    w_mag = {r_acc[WIDTH-1:0], r_mplr};
  end
  // FSM, datapath registers and registered Busy/Done/Product
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_mcand   <= '0;
      r_mplr    <= '0;
      r_acc     <= '0;
      r_neg     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (i_start) begin
          r_mcand <= (i_signed && i_a[WIDTH-1]) ? -i_a : i_a;
          r_mplr  <= (i_signed && i_b[WIDTH-1]) ? -i_b : i_b;
          r_neg   <= i_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
          r_acc   <= '0;
          r_count <= CNT_W'(WIDTH);
          r_busy  <= 1'b1;
          r_state <= S_CALC;
        end
        S_CALC: begin
          {r_acc, r_mplr} <= {1'b0, w_sum, r_mplr[WIDTH-1:1]};
          r_count         <= r_count - 1'b1;
          if (r_count == CNT_W'(1)) r_state <= S_FIX;
        end
        S_FIX: begin
          r_product <= r_neg ? -w_mag : w_mag;
          r_busy    <= 1'b0;
          r_done    <= 1'b1;
          r_state   <= S_DONE;
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_product = r_product;
endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb_mult_seq_ctrl: randomized self-checking bench against an arithmetic product model
module tb_mult_seq_ctrl;
  localparam int W = 32;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          sgn = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          busy;
  logic          done;
  logic [2*W-1:0] product;
  logic [2*W-1:0] exp_prev = '0;
  int errors = 0;
  int checks = 0;

  mult_seq_ctrl #(.WIDTH(W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_signed(sgn),
    .i_a(a), .i_b(b), .o_busy(busy), .o_done(done), .o_product(product)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    longint p;
    if (s) begin
      p = longint'($signed(x)) * longint'($signed(y));
      return p;
    end
    return {32'b0, x} * {32'b0, y};
  endfunction

  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s, input bit disturb, input string name);
    logic [2*W-1:0] e;
    int nb;
    bit bad;
    e = model(x, y, s);
    @(negedge clk);
    a = x; b = y; sgn = s; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    nb = 0;
    bad = 0;
    for (int i = 0; i < W + 1; i++) begin
      @(negedge clk);
      if (busy) nb++;
      if (done || product !== exp_prev) bad = 1;
      if (disturb && i == 10) begin
        start = 1'b1; a = $urandom; b = $urandom; sgn = ~s;
      end
      if (disturb && i == 11) start = 1'b0;
    end
    checks++;
    if (nb !== W + 1) begin errors++; $display("FAIL %s busy_cycles got=%0d exp=%0d", name, nb, W + 1); end
    checks++;
    if (bad) begin errors++; $display("FAIL %s early_done_or_product_change got=1 exp=0", name); end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL %s done_pulse got done=%b busy=%b exp done=1 busy=0", name, done, busy); end
    checks++;
    if (product !== e) begin errors++; $display("FAIL %s product got=%h exp=%h (a=%h b=%h s=%b)", name, product, e, x, y, s); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || product !== e) begin
      errors++; $display("FAIL %s after_done got done=%b busy=%b prod=%h exp done=0 busy=0 prod=%h", name, done, busy, product, e);
    end
    exp_prev = e;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
      errors++; $display("FAIL reset_state got busy=%b done=%b prod=%h exp 0 0 0", busy, done, product);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL idle_hold got busy=%b done=%b exp 0 0", busy, done); end
    exp_prev = '0;
  endtask

  task automatic test_directed;
    do_op(32'd7, 32'd6, 1'b0, 0, "multu_7x6");
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, "multu_max");
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, "mult_m1");
    do_op(-32'sd3, 32'd5, 1'b1, 0, "mult_m3x5");
    do_op(32'h8000_0000, 32'h8000_0000, 1'b1, 0, "mult_minint");
    do_op(32'h0, 32'h1234_5678, 1'b1, 0, "mult_zero");
  endtask

  task automatic test_ignore_start;
    do_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1, "ignore_start_signed");
    do_op(32'hDEAD_BEEF, 32'h0000_0101, 1'b0, 1, "ignore_start_unsigned");
  endtask

  task automatic test_random;
    logic [W-1:0] x, y;
    for (int i = 0; i < 20; i++) begin
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 3) == 0) x = ($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'hFFFF_FFFF;
      do_op(x, y, 1'($urandom_range(0, 1)), 0, "random");
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] xa [4];
    logic [W-1:0] xb [4];
    logic [2*W-1:0] e;
    int nb;
    for (int k = 0; k < 4; k++) begin xa[k] = $urandom; xb[k] = $urandom; end
    @(negedge clk);
    a = xa[0]; b = xb[0]; sgn = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 a = xa[1]; b = xb[1];
    for (int k = 0; k < 3; k++) begin
      nb = 0;
      for (int i = 0; i < W + 1; i++) begin
        @(negedge clk);
        if (busy && !done) nb++;
      end
      checks++;
      if (nb !== W + 1) begin errors++; $display("FAIL b2b_busy op%0d got=%0d exp=%0d", k, nb, W + 1); end
      @(negedge clk);
      e = model(xa[k], xb[k], 1'b1);
      checks++;
      if (done !== 1'b1 || product !== e) begin
        errors++; $display("FAIL b2b_result op%0d got done=%b prod=%h exp done=1 prod=%h", k, done, product, e);
      end
      exp_prev = e;
      if (k == 2) start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 a = xa[(k + 2) % 4]; b = xb[(k + 2) % 4];
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== exp_prev) begin
      errors++; $display("FAIL b2b_stop got busy=%b done=%b prod=%h exp 0 0 %h", busy, done, product, exp_prev);
    end
  endtask

  task automatic test_reset_mid;
    bit bad;
    @(negedge clk);
    a = 32'd1000; b = 32'd1000; sgn = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
      errors++; $display("FAIL reset_mid got busy=%b done=%b prod=%h exp 0 0 0", busy, done, product);
    end
    exp_prev = '0;
    bad = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (busy || done || product !== '0) bad = 1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL reset_mid_quiet got=activity exp=idle"); end
    do_op(32'hFFFF_FFF9, 32'd9, 1'b1, 0, "after_reset");
  endtask

  initial begin
    test_reset;
    test_directed;
    test_ignore_start;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
